pipe_ctrl_unit: RTL
===================

// Module: pipe_ctrl_unit
// PURPOSE
//  Central sequencer for the 5-stage pipeline latches (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC.
//  Drives every latch ena/flush from a run/step/halt FSM plus load-use and branch hazard logic.
//  Sits beside the decode stage; the debug unit drives start/mode/step, WB reports the halt instruction.
// PARAMETERS
//  W      5   register-index width (rs/rt fields)
//  CNT_W  32  width of cycle counter (and stall counter when enabled)
// PORTS
//  clk          in   1      system clock, all state on posedge
//  reset        in   1      asynchronous, active-low reset (0 = reset)
//  start        in   1      leave IDLE; sampled only in IDLE
//  mode_step    in   1      1 = single-step mode, 0 = free run; sampled with start
//  step_req     in   1      step request; each rising edge = one pipeline advance
//  id_rs        in   W      rs field of instruction in ID
//  id_rt        in   W      rt field of instruction in ID
//  id_uses_rt   in   1      ID instruction reads rt as a source
//  ex_mem_read  in   1      instruction in EX is a load (ID_EX MemtoReg)
//  ex_rt        in   W      destination rt of instruction in EX
//  branch_taken in   1      branch/jump resolved taken in ID this cycle
//  halt_wb      in   1      halt instruction is in WB this cycle
//  pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena  out 1  latch/PC enables
//  if_id_flush, id_ex_flush                              out 1  latch flushes (valid with ena)
//  running      out  1      registered: FSM in RUN/STEP_WAIT/STEP_GO
//  halted       out  1      registered: FSM in HALTED
//  cycle_cnt    out  CNT_W  registered: number of advance cycles since reset
// BEHAVIOUR
//  FSM states: IDLE, RUN, STEP_WAIT, STEP_GO, HALTED. Reset -> IDLE; outputs 0, cycle_cnt 0.
//  IDLE: start & !mode_step -> RUN; start & mode_step -> STEP_WAIT.
//  STEP_WAIT: step_req rising edge (step_req & !step_req_q) -> STEP_GO; held-high step_req = one step.
//  STEP_GO: exactly one advance cycle, then STEP_WAIT.
//  adv = (state==RUN)|(state==STEP_GO). All ena/flush are combinational from state + inputs.
//  load_use = ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  adv=0: every ena and flush = 0 (pipeline frozen, no bubbles inserted).
//  adv=1 & !load_use: all ena=1; if_id_flush=branch_taken; id_ex_flush=0.
//  adv=1 & load_use: pc_ena=0, if_id_ena=0, id_ex_ena=1, id_ex_flush=1 (bubble), ex_mem/mem_wb ena=1;
//    if_id_flush=0 even if branch_taken (stall wins; branch re-resolves next cycle).
//  halt_wb & adv -> HALTED next cycle; that last cycle still advances. HALTED is terminal until reset.
//  halt_wb while not adv ignored. start ignored outside IDLE.
//  cycle_cnt += 1 on every adv cycle; wraps 2^CNT_W-1 -> 0.
//  Reset asserted mid-run/step: immediate return to IDLE, all outputs 0 without waiting for clk.
// CONFIGURATION
//  PIPE_CTRL_STALL_CNT_EN defined: adds output stall_cnt [CNT_W], reset 0, +1 on each adv&load_use
//    cycle, wraps like cycle_cnt. Undefined: port and counter absent; all else identical.
// STRUCTURE
//  Shared header pipe_ctrl_defs.vh: FSM state encodings (3-bit localparams), default W/CNT_W.
//  Sub-module load_use_detect: combinational load_use compare (W param); rest is FSM + counters.
// TESTING
//  1 reset low, start=1 mode_step=0 -> RUN next clk; all ena=1, flush=0; cycle_cnt 1,2,3...
//  2 RUN, ex_mem_read=1 ex_rt=5 id_rs=5 -> pc_ena=0 if_id_ena=0 id_ex_flush=1 one cycle; ex_rt=0 -> no stall.
//  3 RUN, branch_taken=1 no hazard -> if_id_flush=1 all ena=1; with load_use also -> if_id_flush=0.
//  4 step mode, step_req held high 10 clks -> exactly one adv cycle, cycle_cnt +1; second edge +1.
//  5 RUN, halt_wb=1 -> that cycle adv, then halted=1, all ena=0; start/step_req ignored.
//  6 reset low mid-RUN between edges -> outputs 0 immediately; CNT_W=4 run 16 cycles -> cycle_cnt wraps to 0.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding, default
// widths and the latch-control bundle with its decode function.
package pipe_ctrl_unit_pkg;

    localparam int W_DEF     = 5;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_GO   = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    typedef struct packed {
        logic pc_ena;
        logic if_id_ena;
        logic id_ex_ena;
        logic ex_mem_ena;
        logic mem_wb_ena;
        logic if_id_flush;
        logic id_ex_flush;
    } latch_ctl_t;

    // Frozen when not advancing; a load-use stall holds PC/IF_ID and bubbles
    // ID_EX, and it overrides a taken branch (the branch re-resolves next cycle).
    function automatic latch_ctl_t latch_ctl(input logic adv,
                                             input logic load_use,
                                             input logic branch_taken);
        latch_ctl_t c;
        c = '0;
        if (adv) begin
            c.id_ex_ena  = 1'b1;
            c.ex_mem_ena = 1'b1;
            c.mem_wb_ena = 1'b1;
            if (load_use) begin
                c.id_ex_flush = 1'b1;
            end else begin
                c.pc_ena      = 1'b1;
                c.if_id_ena   = 1'b1;
                c.if_id_flush = branch_taken;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Pipeline-side bundle of the sequencer: hazard inputs from ID/EX/WB and
// the enable/flush controls going back to the PC and pipeline latches.
interface pipe_ctrl_unit_if #(
    parameter int W = 5
);
    logic [W-1:0] id_rs;
    logic [W-1:0] id_rt;
    logic         id_uses_rt;
    logic         ex_mem_read;
    logic [W-1:0] ex_rt;
    logic         branch_taken;
    logic         halt_wb;

    logic pc_ena;
    logic if_id_ena;
    logic id_ex_ena;
    logic ex_mem_ena;
    logic mem_wb_ena;
    logic if_id_flush;
    logic id_ex_flush;

    // Sequencer side: drives latch controls, observes hazards.
    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, halt_wb,
        output pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena,
               if_id_flush, id_ex_flush
    );

    // Pipeline side: reports hazards, obeys latch controls.
    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, halt_wb,
        input  pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena,
               if_id_flush, id_ex_flush
    );
endinterface

// File: rtl/pipe_ctrl_unit_load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID
// instruction reads. Register 0 is never a real dependency.
module load_use_detect #(
    parameter int W = 5
) (
    input  logic         ex_mem_read,
    input  logic [W-1:0] ex_rt,
    input  logic [W-1:0] id_rs,
    input  logic [W-1:0] id_rt,
    input  logic         id_uses_rt,
    output logic         load_use
);
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Central sequencer for the PC and IF_ID/ID_EX/EX_MEM/MEM_WB latches:
// run / single-step / halt FSM plus load-use and branch hazard control.
// Optional feature: define PIPE_CTRL_STALL_CNT_EN to add the stall_cnt
// output counting load-use stall cycles.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_step,
    input  logic             step_req,
    pipe_ctrl_unit_if.master pipe,
    output logic             running,
    output logic             halted,
`ifdef PIPE_CTRL_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t     state, next_state;
    logic       step_req_q;
    logic       adv;
    logic       load_use;
    latch_ctl_t ctl;

    load_use_detect #(.W(W)) u_load_use (
        .ex_mem_read (pipe.ex_mem_read),
        .ex_rt       (pipe.ex_rt),
        .id_rs       (pipe.id_rs),
        .id_rt       (pipe.id_rt),
        .id_uses_rt  (pipe.id_uses_rt),
        .load_use    (load_use)
    );

    // Next-state and latch-control decode from current state and hazards.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        next_state = state;
        adv        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = mode_step ? ST_STEP_WAIT : ST_RUN;
            end
            ST_RUN: begin
                adv = 1'b1;
                if (pipe.halt_wb) next_state = ST_HALTED;
            end
            ST_STEP_WAIT: begin
                if (step_req && !step_req_q) next_state = ST_STEP_GO;
            end
            ST_STEP_GO: begin
                adv        = 1'b1;
                next_state = pipe.halt_wb ? ST_HALTED : ST_STEP_WAIT;
            end
            ST_HALTED: begin
                next_state = ST_HALTED;
            end
            default: next_state = ST_IDLE;
        endcase
        ctl = latch_ctl(adv, load_use, pipe.branch_taken);
    end

    assign pipe.pc_ena      = ctl.pc_ena;
    assign pipe.if_id_ena   = ctl.if_id_ena;
    assign pipe.id_ex_ena   = ctl.id_ex_ena;
    assign pipe.ex_mem_ena  = ctl.ex_mem_ena;
    assign pipe.mem_wb_ena  = ctl.mem_wb_ena;
    assign pipe.if_id_flush = ctl.if_id_flush;
    assign pipe.id_ex_flush = ctl.id_ex_flush;

    // State register, step-edge history and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: async reset drops the FSM to IDLE at once, which zeroes every
        // enable combinationally; state updates use non-blocking assignment.
        if (!reset) begin
            state      <= ST_IDLE;
            step_req_q <= 1'b0;
            running    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= next_state;
            step_req_q <= step_req;
            running    <= next_state inside {ST_RUN, ST_STEP_WAIT, ST_STEP_GO};
            halted     <= (next_state == ST_HALTED);
        end
    end

    // Advance-cycle counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   cycle_cnt <= '0;
        else if (adv) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    // Load-use stall counter, wraps like cycle_cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               stall_cnt <= '0;
        else if (adv && load_use) stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif

endmodule
